lcd_write_arbiter: RTL and testbench

//  Shares the single character-LCD bus between NREQ byte-write clients: access control,

---
 rtl/lcd_arb_pkg.sv | 41 ++++
 rtl/lcd_rr_arbiter.sv | 56 +++++
 rtl/lcd_write_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_lcd_write_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_arb_pkg.sv
// ----------------------------------------------------------------------------
// lcd_arb_pkg
// Shared definitions for the character-LCD write arbiter:
//   - lcd_state_t     : write-sequencer states
//   - LCD_CMD_CLEAR / LCD_CMD_HOME : HD44780 commands that need the long wait
//   - DEF_*           : default timing (cycles at 50 MHz) and requester count
//   - CL_*            : client index assignments on the req/ack vectors
//   - IDX_W           : width of a client index (owner output)
//   - max_int()       : helper used to size the timing counter
// ----------------------------------------------------------------------------
package lcd_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_PULSE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_WAIT  = 3'd4
   } lcd_state_t;

   localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

   localparam int DEF_NREQ    = 3;
   localparam int DEF_T_SETUP = 2;
   localparam int DEF_T_EN    = 12;
   localparam int DEF_T_HOLD  = 2;
   localparam int DEF_T_GAP   = 2000;
   localparam int DEF_T_CLR   = 82000;

   // Client indices; owner is two bits wide, so at most four clients.
   localparam int IDX_W     = 2;
   localparam int CL_ACCESS = 0;
   localparam int CL_GAME   = 1;
   localparam int CL_SCORE  = 2;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// ----------------------------------------------------------------------------
// lcd_rr_arbiter
// Round-robin pointer and priority search for the LCD write clients.
// The search starts at pointer+1 and wraps, so the client granted last has
// the lowest priority next time. The pointer moves to the grant only when
// the sequencer asserts advance.
// Ports:
//   clk      in   clock
//   rst      in   synchronous reset, active-low (pointer -> NREQ-1)
//   req      in   NREQ  pending requests
//   advance  in   1     move pointer to the current grant
//   grant    out  IDX_W index of the winning client (pointer when no req)
//   valid    out  1     at least one request pending
// ----------------------------------------------------------------------------
module lcd_rr_arbiter
   import lcd_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   input  logic             advance,
   output logic [IDX_W-1:0] grant,
   output logic             valid
);

   logic [IDX_W-1:0] ptr;
   logic             found;
   int               idx;

   // Scan pointer+1, pointer+2, ... pointer (mod NREQ); first set bit wins.
   always_comb begin
      grant = ptr;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            grant = IDX_W'(idx);
         end
      end
   end

   assign valid = |req;

   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr <= IDX_W'(NREQ - 1);
      end else if (advance && valid) begin
         ptr <= grant;
      end
   end

endmodule

// File: rtl/lcd_write_arbiter.sv
// ----------------------------------------------------------------------------
// lcd_write_arbiter
// Shares one HD44780 character-LCD bus between NREQ byte-write clients
// (0 = access control, 1 = game, 2 = scoreboard). In IDLE one pending
// client is chosen round-robin, its byte and register select are latched
// onto the LCD pins and it receives a one-cycle ack. The byte is then
// written with the HD44780 timing: SETUP, enable PULSE, HOLD, and an
// execution WAIT that is longer after clear/home commands.
//
// Optional feature (macro LCD_ARB_LOCK_EN): when defined, a client that owns
// the bus and holds both req and lock is granted again ahead of round-robin,
// so multi-character strings are written without interleaving. When the
// macro is not defined the lock input is ignored.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous reset, active-low
//   req       in   NREQ    write request per client, held until ack
//   rs_in     in   NREQ    register select per client (0 command, 1 data)
//   data_in   in   8*NREQ  byte per client, client i on [8*i+7:8*i]
//   lock      in   NREQ    burst lock (used only with LCD_ARB_LOCK_EN)
//   ack       out  NREQ    one-cycle pulse when the client's byte is latched
//   owner     out  2       index of the last granted client
//   busy      out  1       high in every state except IDLE
//   lcd_data  out  8       LCD data bus
//   lcd_rs    out  1       LCD register select
//   lcd_rw    out  1       LCD read/write, always 0 (write only)
//   lcd_en    out  1       LCD enable strobe
// ----------------------------------------------------------------------------
module lcd_write_arbiter
   import lcd_arb_pkg::*;
#(
   parameter int NREQ    = DEF_NREQ,
   parameter int T_SETUP = DEF_T_SETUP,
   parameter int T_EN    = DEF_T_EN,
   parameter int T_HOLD  = DEF_T_HOLD,
   parameter int T_GAP   = DEF_T_GAP,
   parameter int T_CLR   = DEF_T_CLR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   rs_in,
   input  logic [8*NREQ-1:0] data_in,
   input  logic [NREQ-1:0]   lock,
   output logic [NREQ-1:0]   ack,
   output logic [IDX_W-1:0]  owner,
   output logic              busy,
   output logic [7:0]        lcd_data,
   output logic              lcd_rs,
   output logic              lcd_rw,
   output logic              lcd_en
);

   localparam int T_MAX = max_int(max_int(max_int(T_SETUP, T_EN), max_int(T_HOLD, T_GAP)), T_CLR);
   localparam int CNT_W = $clog2(T_MAX) + 1;

   lcd_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [NREQ-1:0]  ack_nxt;
   logic [IDX_W-1:0] owner_nxt;
   logic [7:0]       data_nxt;
   logic             rs_nxt;
   logic             advance;
   logic             cnt_last;
   logic             long_wait;

   logic [IDX_W-1:0] arb_grant;
   logic             arb_valid;
   logic [IDX_W-1:0] gsel;
   logic             lock_hit;

   lcd_rr_arbiter #(
      .NREQ    (NREQ)
   ) u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (advance),
      .grant   (arb_grant),
      .valid   (arb_valid)
   );

   // Grant selection: round-robin winner, optionally overridden by a locked owner.
   always_comb begin
      gsel     = arb_grant;
      lock_hit = 1'b0;
`ifdef LCD_ARB_LOCK_EN
      if (req[owner] && lock[owner]) begin
         lock_hit = 1'b1;
         gsel     = owner;
      end
`endif
   end

`ifndef LCD_ARB_LOCK_EN
   logic unused_lock;
   assign unused_lock = ^lock;
`endif

   // Clear and home take far longer to execute than any other byte.
   assign long_wait = !lcd_rs && ((lcd_data == LCD_CMD_CLEAR) || (lcd_data == LCD_CMD_HOME));
   assign cnt_last  = (cnt == CNT_W'(1));

   // Next-state and registered-output logic.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ack_nxt   = '0;
      owner_nxt = owner;
      data_nxt  = lcd_data;
      rs_nxt    = lcd_rs;
      advance   = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (arb_valid) begin
               state_nxt     = ST_SETUP;
               cnt_nxt       = CNT_W'(T_SETUP);
               ack_nxt[gsel] = 1'b1;
               owner_nxt     = gsel;
               data_nxt      = data_in[8*int'(gsel) +: 8];
               rs_nxt        = rs_in[gsel];
               // A locked re-grant goes to the owner, which is already the pointer.
               advance       = !lock_hit;
            end
         end
         ST_SETUP: begin
            if (cnt_last) begin
               state_nxt = ST_PULSE;
               cnt_nxt   = CNT_W'(T_EN);
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_PULSE: begin
            if (cnt_last) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = CNT_W'(T_HOLD);
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (cnt_last) begin
               state_nxt = ST_WAIT;
               cnt_nxt   = long_wait ? CNT_W'(T_CLR) : CNT_W'(T_GAP);
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (cnt_last) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         ack      <= '0;
         owner    <= IDX_W'(NREQ - 1);
         lcd_data <= '0;
         lcd_rs   <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         ack      <= ack_nxt;
         owner    <= owner_nxt;
         lcd_data <= data_nxt;
         lcd_rs   <= rs_nxt;
      end
   end

   // Enable is decoded from state so a reset edge drops it immediately.
   assign lcd_en = (state == ST_PULSE);
   assign busy   = (state != ST_IDLE);
   assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_lcd_write_arbiter
// Directed bench for lcd_write_arbiter with short timing
// (T_SETUP=1 T_EN=2 T_HOLD=1 T_GAP=4 T_CLR=10). Follows LCD_ARB_LOCK_EN
// if it is defined for the build.
// ----------------------------------------------------------------------------
module tb_lcd_write_arbiter;
   import lcd_arb_pkg::*;

   localparam int NREQ = 3;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   rs_in;
   logic [8*NREQ-1:0] data_in;
   logic [NREQ-1:0]   lock;
   logic [NREQ-1:0]   ack;
   logic [IDX_W-1:0]  owner;
   logic              busy;
   logic [7:0]        lcd_data;
   logic              lcd_rs;
   logic              lcd_rw;
   logic              lcd_en;

   int total = 0;
   int bad   = 0;

   lcd_write_arbiter #(
      .NREQ     (NREQ),
      .T_SETUP  (1),
      .T_EN     (2),
      .T_HOLD   (1),
      .T_GAP    (4),
      .T_CLR    (10)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .rs_in    (rs_in),
      .data_in  (data_in),
      .lock     (lock),
      .ack      (ack),
      .owner    (owner),
      .busy     (busy),
      .lcd_data (lcd_data),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_en   (lcd_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int idx_of(input logic [NREQ-1:0] a);
      for (int i = 0; i < NREQ; i++) if (a[i]) return i;
      return -1;
   endfunction

   // Wait for the next ack; idx=-1 if none within the limit.
   task automatic wait_ack(input int limit, output int idx, output int cycles);
      idx    = -1;
      cycles = 0;
      for (int i = 1; i <= limit; i++) begin
         tick();
         if (ack != '0) begin
            idx    = idx_of(ack);
            cycles = i;
            return;
         end
      end
   endtask

   // Called on the first busy sample; counts busy and enable cycles until IDLE.
   task automatic measure(output int busy_n, output int en_n);
      busy_n = 0;
      en_n   = 0;
      for (int i = 0; i < 200; i++) begin
         if (!busy) return;
         busy_n++;
         if (lcd_en) en_n++;
         tick();
      end
      busy_n = -1;
   endtask

   // Continuous protocol monitor.
   logic       prev_en;
   logic [7:0] prev_data;
   logic       prev_rs;
   initial prev_en = 1'b0;

   always @(negedge clk) begin
      check("lcd_rw_zero", 32'(lcd_rw), 0);
      check("ack_onehot0", 32'($onehot0(ack)), 1);
      if (lcd_en && prev_en) begin
         check("data_stable_en", 32'(lcd_data), 32'(prev_data));
         check("rs_stable_en", 32'(lcd_rs), 32'(prev_rs));
      end
      prev_en   <= lcd_en;
      prev_data <= lcd_data;
      prev_rs   <= lcd_rs;
   end

   initial begin
      int idx, cyc, bn, en;

      // Reset values
      rst = 1'b0; req = '0; rs_in = '0; data_in = '0; lock = '0;
      tick(); tick();
      check("rst_ack", 32'(ack), 0);
      check("rst_owner", 32'(owner), 2);
      check("rst_busy", 32'(busy), 0);
      check("rst_data", 32'(lcd_data), 0);
      check("rst_rs", 32'(lcd_rs), 0);
      check("rst_en", 32'(lcd_en), 0);
      rst = 1'b1;
      tick();
      check("idle_no_req_busy", 32'(busy), 0);

      // Single byte from the game client
      data_in[15:8] = 8'h41; rs_in[CL_GAME] = 1'b1; req = 3'b010;
      wait_ack(5, idx, cyc);
      check("single_ack_idx", 32'(idx), 1);
      check("single_ack_lat", 32'(cyc), 1);
      check("single_owner", 32'(owner), 1);
      check("single_data", 32'(lcd_data), 32'h41);
      check("single_rs", 32'(lcd_rs), 1);
      req = '0;
      measure(bn, en);
      check("single_busy_cycles", 32'(bn), 8);
      check("single_en_cycles", 32'(en), 2);
      tick(); tick();
      check("idle_hold_data", 32'(lcd_data), 32'h41);
      check("idle_hold_ack", 32'(ack), 0);

      // Contention from reset: order 0,1,2,0, one byte per 9 cycles
      rst = 1'b0; tick(); rst = 1'b1;
      data_in = {8'h32, 8'h31, 8'h30}; rs_in = 3'b111; req = 3'b111;
      wait_ack(5, idx, cyc);
      check("cont_g0", 32'(idx), 0);
      check("cont_g0_data", 32'(lcd_data), 32'h30);
      wait_ack(20, idx, cyc);
      check("cont_g1", 32'(idx), 1);
      check("cont_g1_period", 32'(cyc), 9);
      check("cont_g1_data", 32'(lcd_data), 32'h31);
      wait_ack(20, idx, cyc);
      check("cont_g2", 32'(idx), 2);
      check("cont_g2_period", 32'(cyc), 9);
      check("cont_g2_data", 32'(lcd_data), 32'h32);
      wait_ack(20, idx, cyc);
      check("cont_g3", 32'(idx), 0);
      check("cont_g3_period", 32'(cyc), 9);
      req = '0;
      measure(bn, en);
      check("cont_drain", 32'(bn), 8);

      // Clear command takes the long wait
      data_in[7:0] = LCD_CMD_CLEAR; rs_in[0] = 1'b0; req = 3'b001;
      wait_ack(5, idx, cyc);
      check("clr_ack", 32'(idx), 0);
      check("clr_rs", 32'(lcd_rs), 0);
      req = '0;
      measure(bn, en);
      check("clr_busy_cycles", 32'(bn), 14);
      check("clr_en_cycles", 32'(en), 2);

      // Ordinary command 0x38 takes the short wait
      data_in[7:0] = 8'h38; req = 3'b001;
      wait_ack(5, idx, cyc);
      req = '0;
      measure(bn, en);
      check("cmd38_busy_cycles", 32'(bn), 8);

      // Home command takes the long wait
      data_in[7:0] = LCD_CMD_HOME; req = 3'b001;
      wait_ack(5, idx, cyc);
      req = '0;
      measure(bn, en);
      check("home_busy_cycles", 32'(bn), 14);

      // 0x01 sent as data is not a clear
      data_in[7:0] = 8'h01; rs_in[0] = 1'b1; req = 3'b001;
      wait_ack(5, idx, cyc);
      req = '0;
      measure(bn, en);
      check("data01_busy_cycles", 32'(bn), 8);

      // Reset during the enable pulse
      data_in[15:8] = 8'h55; req = 3'b010;
      wait_ack(5, idx, cyc);
      check("rstmid_ack", 32'(idx), 1);
      req = '0;
      tick();
      check("rstmid_en_high", 32'(lcd_en), 1);
      rst = 1'b0;
      tick();
      check("rstmid_en_drop", 32'(lcd_en), 0);
      check("rstmid_busy", 32'(busy), 0);
      check("rstmid_ack0", 32'(ack), 0);
      check("rstmid_owner", 32'(owner), 2);
      tick();
      rst = 1'b1; req = 3'b011;
      wait_ack(5, idx, cyc);
      check("rstmid_restart_g", 32'(idx), 0);
      check("rstmid_restart_lat", 32'(cyc), 1);
      req = '0;
      measure(bn, en);
      check("rstmid_restart_busy", 32'(bn), 8);

      // Burst lock on client 0
      rst = 1'b0; tick(); rst = 1'b1;
      req = 3'b011; lock = 3'b001;
      wait_ack(5, idx, cyc);
      check("lock_g0", 32'(idx), 0);
      wait_ack(20, idx, cyc);
`ifdef LCD_ARB_LOCK_EN
      check("lock_g1", 32'(idx), 0);
`else
      check("lock_g1", 32'(idx), 1);
`endif
      wait_ack(20, idx, cyc);
      check("lock_g2", 32'(idx), 0);
      lock = '0;
      wait_ack(20, idx, cyc);
      check("lock_release_g", 32'(idx), 1);
      req = '0;
      measure(bn, en);
      check("lock_drain", 32'(bn), 8);

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
